// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD host DAT path: FSM encoding and the CRC16-CCITT step.
package sd_dat_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_DATA       = 3'd2;
  localparam logic [2:0] ST_CRC        = 3'd3;
  localparam logic [2:0] ST_END        = 3'd4;
  localparam logic [2:0] ST_HOLD       = 3'd5;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  // One serial CRC16 step, bits fed in line order.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT accumulator; shared between the DAT RX and TX paths.
module sd_crc16_serial
  import sd_dat_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        crc_q <= CRC16_INIT;
    else if (clear)    crc_q <= CRC16_INIT;
    else if (shift_en) crc_q <= crc16_step(crc_q, in);
  end

  assign crc = crc_q;

endmodule

// File: rtl/dat_rx_deserializer.sv
// DAT-line receiver: start-bit detect, LSB-first deserialize, CRC16/end-bit check,
// then hand the word and status to the DAT controller over valid/ready.
module dat_rx_deserializer
  import sd_dat_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int BITS_COUNTER = 6,
  parameter int TIMEOUT      = 1024,
  parameter int TO_WIDTH     = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            in,
  input  logic            ready,
  output logic [BITS-1:0] data,
  output logic            valid,
  output logic            crc_err,
  output logic            end_err,
  output logic            timeout,
  output logic            complete
);

  localparam logic [BITS_COUNTER-1:0] DATA_LAST = BITS_COUNTER'(BITS - 1);
  localparam logic [BITS_COUNTER-1:0] CRC_LAST  = BITS_COUNTER'(15);
  localparam logic [TO_WIDTH-1:0]     TO_LAST   = TO_WIDTH'(TIMEOUT - 1);

  logic [2:0]              state_q, state_d;
  logic [BITS_COUNTER-1:0] cnt_q, cnt_d;
  logic [TO_WIDTH-1:0]     to_q, to_d;
  logic [BITS-1:0]         data_q, data_d;
  logic [15:0]             rx_crc_q, rx_crc_d;
  logic                    valid_q, valid_d;
  logic                    crc_err_q, crc_err_d;
  logic                    end_err_q, end_err_d;
  logic                    to_flag_q, to_flag_d;
  logic                    crc_clear, crc_shift;
  logic [15:0]             crc;
  logic                    hs;

  sd_crc16_serial u_crc (
    .clk      (clk),
    .reset    (reset),
    .clear    (crc_clear),
    .shift_en (crc_shift),
    .in       (in),
    .crc      (crc)
  );

  assign hs = valid_q & ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    data_d    = data_q;
    rx_crc_d  = rx_crc_q;
    valid_d   = valid_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    to_flag_d = to_flag_q;
    crc_clear = 1'b0;
    crc_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        to_d  = '0;
        if (enable) state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!enable) begin
          state_d = ST_IDLE;
          to_d    = '0;
        end else if (!in) begin
          state_d   = ST_DATA;
          cnt_d     = '0;
          to_d      = '0;
          rx_crc_d  = CRC16_INIT;
          crc_clear = 1'b1;
        end else if (to_q >= TO_LAST) begin
          state_d   = ST_HOLD;
          to_d      = '0;
          data_d    = '0;
          valid_d   = 1'b1;
          to_flag_d = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          // Shift right so the first bit received lands in data[0] after BITS bits.
          data_d    = {in, data_q[BITS-1:1]};
          crc_shift = 1'b1;
          if (cnt_q >= DATA_LAST) begin
            state_d = ST_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_CRC: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          rx_crc_d = {rx_crc_q[14:0], in};
          if (cnt_q >= CRC_LAST) begin
            state_d = ST_END;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_END: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          end_err_d = ~in;
          crc_err_d = (rx_crc_q != crc);
          valid_d   = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // enable is deliberately ignored until the word has been taken.
        if (hs) begin
          valid_d   = 1'b0;
          crc_err_d = 1'b0;
          end_err_d = 1'b0;
          to_flag_d = 1'b0;
          state_d   = enable ? ST_WAIT_START : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      to_q      <= '0;
      data_q    <= '0;
      rx_crc_q  <= CRC16_INIT;
      valid_q   <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
      to_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      data_q    <= data_d;
      rx_crc_q  <= rx_crc_d;
      valid_q   <= valid_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign crc_err  = crc_err_q;
  assign end_err  = end_err_q;
  assign timeout  = to_flag_q;
  assign complete = hs;

endmodule

// File: tb/tb_dat_rx_deserializer.sv
// Scoreboard bench for the DAT receiver: directed frames in, expected words queued,
// monitor pops and compares on every valid&ready handshake.
module tb_dat_rx_deserializer;

  localparam int BITS = 32;

  logic            clk = 1'b0;
  logic            reset, enable, in, ready;
  logic [BITS-1:0] data;
  logic            valid, crc_err, end_err, timeout, complete;

  always #5 clk = ~clk;

  dat_rx_deserializer #(
    .BITS(BITS), .BITS_COUNTER(6), .TIMEOUT(16), .TO_WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .in(in), .ready(ready),
    .data(data), .valid(valid), .crc_err(crc_err), .end_err(end_err),
    .timeout(timeout), .complete(complete)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        ce;
    logic        ee;
    logic        to;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  localparam logic [31:0] GOOD = 32'hA5A5_0F0F;
  localparam logic [31:0] BP_D = 32'h1234_5678;
  localparam logic [31:0] LAST = 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] crc_of(input logic [31:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic fbit(input logic [31:0] d, input logic [15:0] c, input logic e, input int i);
    if (i == 0)       return 1'b0;
    else if (i <= 32) return d[i-1];
    else if (i <= 48) return c[48-i];
    else              return e;
  endfunction

  // Monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && valid && ready) begin
      if (sbq.size() == 0) chk("unexpected_valid", sbq.size(), 1);
      else begin
        mon_e = sbq.pop_front();
        chk("data",     data,     mon_e.d);
        chk("crc_err",  crc_err,  mon_e.ce);
        chk("end_err",  end_err,  mon_e.ee);
        chk("timeout",  timeout,  mon_e.to);
        chk("complete", complete, 1);
      end
    end
  end

  task automatic start_frame();
    enable = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives the first n line bits, one per cycle; a full frame is 50 bits.
  task automatic drive_frame(input logic [31:0] d, input logic [15:0] c, input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      in = fbit(d, c, e, i);
      if (n == 50 && i == 49) chk("valid_early", valid, 0);
      @(posedge clk); #1;
    end
    in = 1'b1;
    if (n == 50) chk("valid_latency", valid, 1);
  endtask

  task automatic good_frame(input logic [31:0] d, input logic [15:0] c, input logic e,
                            input logic ce, input logic ee);
    sbq.push_back({d, ce, ee, 1'b0});
    start_frame();
    drive_frame(d, c, e, 50);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic seen;

  initial begin
    reset = 1'b0; enable = 1'b0; in = 1'b1; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",    valid,    0);
    chk("rst_data",     data,     0);
    chk("rst_crc_err",  crc_err,  0);
    chk("rst_end_err",  end_err,  0);
    chk("rst_timeout",  timeout,  0);
    chk("rst_complete", complete, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    good_frame(GOOD, crc_of(GOOD), 1'b1, 1'b0, 1'b0);
    good_frame(32'h0, 16'h0000, 1'b1, 1'b0, 1'b0);
    good_frame(32'h0, 16'h0001, 1'b1, 1'b1, 1'b0);
    good_frame(GOOD, crc_of(GOOD), 1'b0, 1'b0, 1'b1);

    // Backpressure: word and status must stay frozen while ready is low.
    ready = 1'b0;
    sbq.push_back({BP_D, 1'b0, 1'b1, 1'b0});
    start_frame();
    drive_frame(BP_D, crc_of(BP_D), 1'b0, 50);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid",    valid,    1);
      chk("bp_data",     data,     BP_D);
      chk("bp_end_err",  end_err,  1);
      chk("bp_complete", complete, 0);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_clr",    valid,    0);
    chk("bp_complete_clr", complete, 0);
    chk("bp_end_err_clr",  end_err,  0);
    repeat (2) @(posedge clk);
    #1;

    // Timeout: line idle high; then a frame straight out of the re-entered WAIT_START.
    in = 1'b1;
    sbq.push_back({32'h0, 1'b0, 1'b0, 1'b1});
    enable = 1'b1;
    @(posedge clk); #1;
    repeat (15) @(posedge clk);
    #1;
    chk("to_valid_early", valid, 0);
    @(posedge clk); #1;
    chk("to_valid",   valid,   1);
    chk("to_timeout", timeout, 1);
    @(posedge clk); #1;
    chk("to_valid_clr", valid, 0);
    sbq.push_back({GOOD, 1'b0, 1'b0, 1'b0});
    drive_frame(GOOD, crc_of(GOOD), 1'b1, 50);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Abort on enable drop at data bit 12.
    start_frame();
    drive_frame(GOOD, crc_of(GOOD), 1'b1, 13);
    enable = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      seen = seen | valid | complete;
    end
    chk("abort_no_valid", seen, 0);

    // Async reset at CRC bit 5.
    start_frame();
    drive_frame(GOOD, crc_of(GOOD), 1'b1, 38);
    reset = 1'b0;
    #1;
    chk("mrst_valid",    valid,    0);
    chk("mrst_data",     data,     0);
    chk("mrst_crc_err",  crc_err,  0);
    chk("mrst_end_err",  end_err,  0);
    chk("mrst_timeout",  timeout,  0);
    chk("mrst_complete", complete, 0);
    enable = 1'b0; in = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    good_frame(LAST, crc_of(LAST), 1'b1, 1'b0, 1'b0);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
